// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble converter: one shift-add-3 iteration per clock.
// Display-facing outputs (bcd, neg, digit_en) only change on the done edge or reset.
module bin_to_bcd_seq #(
  parameter int W      = 16,
  parameter int DIGITS = 5,
  parameter int CW     = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  signed_mode,
  input  logic [W-1:0]          bin_in,
  output logic                  busy,
  output logic                  done,
  output logic                  neg,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [DIGITS-1:0]     digit_en
);

  localparam int BW = 4 * DIGITS;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state;
  logic [CW-1:0]    count;
  logic [W-1:0]     mag;
  logic [BW-1:0]    scratch;
  logic             sign_q;

  logic [BW-1:0]    adj;
  logic [BW+W-1:0]  shifted;
  logic [BW-1:0]    result;
  logic [DIGITS-1:0] en_next;
  logic             capture_sign;
  logic [W-1:0]     capture_mag;

  // Negating at W bits already maps -2^(W-1) onto 2^(W-1) as an unsigned magnitude.
  assign capture_sign = signed_mode & bin_in[W-1];
  assign capture_mag  = capture_sign ? (~bin_in + W'(1)) : bin_in;

  always_comb begin
    adj = scratch;
    for (int i = 0; i < DIGITS; i++) begin
      if (scratch[4*i +: 4] >= 4'd5)
        adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
    end
  end

  assign shifted = {adj, mag} << 1;
  assign result  = shifted[BW+W-1:W];

  // A digit is significant if it or any more significant digit is nonzero.
  always_comb begin
    logic seen;
    seen    = 1'b0;
    en_next = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      seen       = seen | (result[4*i +: 4] != 4'd0);
      en_next[i] = seen;
    end
    en_next[0] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      count    <= '0;
      mag      <= '0;
      scratch  <= '0;
      sign_q   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      neg      <= 1'b0;
      bcd      <= '0;
      digit_en <= DIGITS'(1);
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            mag     <= capture_mag;
            sign_q  <= capture_sign;
            scratch <= '0;
            count   <= '0;
            busy    <= 1'b1;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          scratch <= result;
          mag     <= shifted[W-1:0];
          count   <= count + CW'(1);
          if (count == CW'(W - 1)) begin
            bcd      <= result;
            digit_en <= en_next;
            neg      <= sign_q & (|result);
            done     <= 1'b1;
            busy     <= 1'b0;
            count    <= '0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Bench for bin_to_bcd_seq: directed handshake cases plus a random sweep
// checked against a plain decimal-arithmetic reference model.
module tb_bin_to_bcd_seq;

  localparam int W = 16;

  logic        clk;
  logic        reset;
  logic        start;
  logic        signed_mode;
  logic [15:0] bin_in;
  logic        busy;
  logic        done;
  logic        neg;
  logic [19:0] bcd;
  logic [4:0]  digit_en;

  int passed = 0;
  int total  = 0;

  bin_to_bcd_seq #(.W(16), .DIGITS(5), .CW(5)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .signed_mode (signed_mode),
    .bin_in      (bin_in),
    .busy        (busy),
    .done        (done),
    .neg         (neg),
    .bcd         (bcd),
    .digit_en    (digit_en)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic int unsigned model_mag(input logic [15:0] v, input logic sm);
    if (sm && v[15]) return 32'd65536 - 32'(v);
    return 32'(v);
  endfunction

  function automatic logic [19:0] model_bcd(input int unsigned m);
    logic [19:0] r;
    int unsigned x;
    r = '0;
    x = m;
    for (int i = 0; i < 5; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic [4:0] model_en(input int unsigned m);
    logic [4:0] e;
    int unsigned p;
    p = 1;
    for (int i = 0; i < 5; i++) begin
      e[i] = (i == 0) || (m >= p);
      p = p * 10;
    end
    return e;
  endfunction

  function automatic logic nibbles_ok(input logic [19:0] b);
    for (int i = 0; i < 5; i++)
      if (b[4*i +: 4] > 4'd9) return 1'b0;
    return 1'b1;
  endfunction

  // Leaves the bench 1ns after the edge that samples start.
  task automatic start_conv(input logic [15:0] v, input logic sm);
    @(negedge clk);
    start       = 1'b1;
    bin_in      = v;
    signed_mode = sm;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(output int lat, output logic busy_ok, output logic held);
    logic [19:0] b0;
    logic        n0;
    logic [4:0]  e0;
    b0      = bcd;
    n0      = neg;
    e0      = digit_en;
    lat     = 0;
    busy_ok = busy;
    held    = 1'b1;
    while (done !== 1'b1 && lat < W + 4) begin
      @(posedge clk);
      #1;
      lat++;
      if (done === 1'b1) begin
        if (busy !== 1'b0) busy_ok = 1'b0;
      end else begin
        if (busy !== 1'b1) busy_ok = 1'b0;
        if (bcd !== b0 || neg !== n0 || digit_en !== e0) held = 1'b0;
      end
    end
  endtask

  task automatic check_result(input logic [15:0] v, input logic sm, input string tag);
    int unsigned m;
    m = model_mag(v, sm);
    check({tag, "_bcd"}, 32'(bcd), 32'(model_bcd(m)));
    check({tag, "_neg"}, 32'(neg), 32'(sm && v[15]));
    check({tag, "_en"}, 32'(digit_en), 32'(model_en(m)));
    check({tag, "_nib"}, 32'(nibbles_ok(bcd)), 32'd1);
    @(posedge clk);
    #1;
    check({tag, "_pulse"}, 32'(done), 32'd0);
  endtask

  task automatic applyStimulus(input logic [15:0] v, input logic sm, input string tag);
    int   lat;
    logic busy_ok;
    logic held;
    start_conv(v, sm);
    wait_done(lat, busy_ok, held);
    check({tag, "_lat"}, 32'(lat), 32'(W));
    check({tag, "_busy"}, 32'(busy_ok), 32'd1);
    check({tag, "_hold"}, 32'(held), 32'd1);
    check_result(v, sm, tag);
  endtask

  initial begin
    int   lat;
    int   c;
    int   dones;
    logic busy_ok;
    logic held;
    logic [15:0] v;
    logic sm;

    reset       = 1'b1;
    start       = 1'b1;
    signed_mode = 1'b0;
    bin_in      = 16'h1234;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_bcd", 32'(bcd), 32'd0);
    check("rst_en", 32'(digit_en), 32'd1);
    check("rst_neg", 32'(neg), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0;

    applyStimulus(16'd0, 1'b0, "zero");
    applyStimulus(16'hFFFF, 1'b0, "max_u");
    applyStimulus(16'hFFFF, 1'b1, "minus1");
    applyStimulus(16'h8000, 1'b1, "min_s");
    applyStimulus(16'h7FFF, 1'b1, "max_s");
    applyStimulus(16'd9, 1'b0, "nine");
    applyStimulus(16'd10, 1'b0, "ten");

    // A second start while busy must be ignored.
    start_conv(16'd1234, 1'b0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    start  = 1'b1;
    bin_in = 16'd9999;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(lat, busy_ok, held);
    check("ovl_lat", 32'(lat), 32'(W - 5));
    check("ovl_hold", 32'(held), 32'd1);
    check("ovl_bcd", 32'(bcd), 32'h01234);
    check("ovl_en", 32'(digit_en), 32'b01111);

    // Start held high: a new conversion every W+1 cycles.
    @(negedge clk);
    start       = 1'b1;
    bin_in      = 16'd500;
    signed_mode = 1'b0;
    c = 0;
    while (done !== 1'b1 && c < 40) begin
      @(posedge clk);
      #1;
      c++;
    end
    c = 0;
    do begin
      @(posedge clk);
      #1;
      c++;
    end while (done !== 1'b1 && c < 40);
    check("b2b_period", 32'(c), 32'(W + 1));
    check("b2b_bcd", 32'(bcd), 32'h00500);
    @(negedge clk);
    start = 1'b0;
    repeat (W + 3) @(posedge clk);

    // Reset in the middle of a conversion aborts it.
    applyStimulus(16'h8000, 1'b1, "pre_rst");
    start_conv(16'd40000, 1'b0);
    repeat (7) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_bcd", 32'(bcd), 32'd0);
    check("abort_en", 32'(digit_en), 32'd1);
    check("abort_neg", 32'(neg), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    dones = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) dones++;
    end
    check("abort_nodone", 32'(dones), 32'd0);
    applyStimulus(16'd255, 1'b0, "post_rst");

    for (int n = 0; n < 2000; n++) begin
      v  = 16'($urandom);
      sm = 1'($urandom_range(0, 1));
      applyStimulus(v, sm, "rand");
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
